// File: rtl/uart_tx_ctrl_if.sv
// Handshake and mux-drive bundle between the UART TX frame controller and its user.
// The master side supplies the byte; the slave side (controller) drives the TX mux controls.
interface uart_tx_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [1:0]            mux_sel;
   logic                  serial_data;
   logic                  parity_bit;
   logic                  busy;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      input  mux_sel, serial_data, parity_bit, busy
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      output mux_sel, serial_data, parity_bit, busy
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: latches a byte, serializes it LSB-first one bit per CLK and
// sequences start/data/parity/stop selects for the downstream registered TX mux.
module uart_tx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic           CLK,
   input logic           RST,
   uart_tx_ctrl_if.slave bus
);
   localparam int unsigned CntW = $clog2(DATA_WIDTH);
   localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [CntW-1:0]       cnt_q;
   logic                  par_en_q;
   logic                  parity_q;
   logic [1:0]            mux_sel;
   logic                  busy;
   logic                  accept;

   assign accept = (state_q == StIdle) && bus.Data_Valid;

   always_comb begin
      state_d = state_q;
      mux_sel = 2'b11;
      busy    = 1'b1;
      case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (bus.Data_Valid) state_d = StStart;
         end
         StStart: begin
            mux_sel = 2'b00;
            state_d = StData;
         end
         StData: begin
            mux_sel = 2'b01;
            if (cnt_q == CntMax) state_d = par_en_q ? StParity : StStop;
         end
         StParity: begin
            mux_sel = 2'b10;
            state_d = StStop;
         end
         StStop: state_d = StIdle;
         default: begin
            busy    = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         shift_q  <= '0;
         cnt_q    <= '0;
         par_en_q <= 1'b0;
         parity_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            shift_q  <= bus.P_DATA;
            par_en_q <= bus.PAR_EN;
            parity_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
         end else if (state_q == StData) begin
            shift_q <= shift_q >> 1;
         end
         // Counter only advances in DATA; any other state holds it at zero.
         if (state_q == StData && cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign bus.mux_sel     = mux_sel;
   assign bus.busy        = busy;
   assign bus.serial_data = shift_q[0];
   assign bus.parity_bit  = parity_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames plus random stimulus, compared each
// cycle against a frame-list reference model.
module tb_uart_tx_ctrl;
   localparam int unsigned DW = 8;

   logic CLK;
   logic RST;
   int   total;
   int   bad;

   uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
      end
   endtask

   // One entry per expected cycle of a frame.
   typedef struct {
      logic [1:0] sel;
      logic       busy;
      logic       has_bit;
      logic       bit_v;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   exp_t idle_e;
   logic exp_par;

   function automatic int count_ones(logic [DW-1:0] v);
      int n = 0;
      for (int i = 0; i < int'(DW); i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic build_frame(input logic [DW-1:0] d, input logic pen);
      exp_t e;
      e = '{sel: 2'b00, busy: 1'b1, has_bit: 1'b0, bit_v: 1'b0};
      q.push_back(e);
      for (int i = 0; i < int'(DW); i++) begin
         e = '{sel: 2'b01, busy: 1'b1, has_bit: 1'b1, bit_v: d[i]};
         q.push_back(e);
      end
      if (pen) begin
         e = '{sel: 2'b10, busy: 1'b1, has_bit: 1'b0, bit_v: 1'b0};
         q.push_back(e);
      end
      e = '{sel: 2'b11, busy: 1'b1, has_bit: 1'b0, bit_v: 1'b0};
      q.push_back(e);
   endtask

   // Reference model steps at each edge, then compares 1 time unit later.
   initial begin
      idle_e  = '{sel: 2'b11, busy: 1'b0, has_bit: 1'b0, bit_v: 1'b0};
      cur     = idle_e;
      exp_par = 1'b0;
      forever begin
         @(posedge CLK);
         if (RST) begin
            q.delete();
            cur     = idle_e;
            exp_par = 1'b0;
         end else if (q.size() != 0) begin
            cur = q.pop_front();
         end else if (cur.busy) begin
            cur = idle_e;
         end else if (bus.Data_Valid) begin
            build_frame(bus.P_DATA, bus.PAR_EN);
            exp_par = 1'((count_ones(bus.P_DATA) % 2) != 0) ^ bus.PAR_TYP;
            cur = q.pop_front();
         end
         #1;
         check("mux_sel", {6'd0, bus.mux_sel}, {6'd0, cur.sel});
         check("busy", {7'd0, bus.busy}, {7'd0, cur.busy});
         check("parity_bit", {7'd0, bus.parity_bit}, {7'd0, exp_par});
         if (cur.has_bit) check("serial_data", {7'd0, bus.serial_data}, {7'd0, cur.bit_v});
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic pen, input logic ptyp);
      @(negedge CLK);
      bus.P_DATA     = d;
      bus.PAR_EN     = pen;
      bus.PAR_TYP    = ptyp;
      bus.Data_Valid = 1'b1;
      @(negedge CLK);
      bus.Data_Valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      RST            = 1'b1;
      bus.P_DATA     = '0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      bus.Data_Valid = 1'b1;
      repeat (2) @(negedge CLK);
      RST            = 1'b0;
      bus.Data_Valid = 1'b0;
      idle_cycles(2);

      // Even parity on 0xA5 is 0; odd parity is 1; even parity on 0x01 is 1.
      send(8'hA5, 1'b1, 1'b0);
      idle_cycles(12);
      check("par_a5_even", {7'd0, bus.parity_bit}, 8'd0);
      send(8'hA5, 1'b1, 1'b1);
      idle_cycles(12);
      check("par_a5_odd", {7'd0, bus.parity_bit}, 8'd1);
      send(8'h01, 1'b1, 1'b0);
      idle_cycles(12);
      check("par_01_even", {7'd0, bus.parity_bit}, 8'd1);

      send(8'h3C, 1'b0, 1'b0);
      idle_cycles(12);

      // Mid-frame input changes and a stray Data_Valid must not disturb the frame in flight.
      send(8'h96, 1'b1, 1'b0);
      idle_cycles(3);
      send(8'hFF, 1'b0, 1'b1);
      idle_cycles(10);

      // Back-to-back frames with Data_Valid held high.
      @(negedge CLK);
      bus.Data_Valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus.P_DATA  = DW'($urandom);
         bus.PAR_EN  = 1'($urandom);
         bus.PAR_TYP = 1'($urandom);
         @(negedge CLK);
      end
      bus.Data_Valid = 1'b0;
      idle_cycles(14);

      // Reset while data bit 3 is on the line, then a fresh frame.
      send(8'h5A, 1'b1, 1'b1);
      idle_cycles(4);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("rst_mid_sel", {6'd0, bus.mux_sel}, 8'h03);
      check("rst_mid_busy", {7'd0, bus.busy}, 8'd0);
      idle_cycles(2);
      send(8'hC3, 1'b1, 1'b0);
      idle_cycles(13);

      // Random stimulus with occasional resets.
      for (int i = 0; i < 600; i++) begin
         @(negedge CLK);
         bus.P_DATA     = DW'($urandom);
         bus.PAR_EN     = 1'($urandom);
         bus.PAR_TYP    = 1'($urandom);
         bus.Data_Valid = ($urandom_range(0, 3) == 0);
         RST            = ($urandom_range(0, 59) == 0);
      end
      @(negedge CLK);
      RST            = 1'b0;
      bus.Data_Valid = 1'b0;
      idle_cycles(15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmitter. It accepts a parallel byte, serializes it LSB-first and computes the parity bit. Each cycle it drives the select, serial-data and parity inputs of the downstream registered TX output mux so that mux produces start, data, optional parity and stop bits. CLK is the bit (baud) clock: one frame bit per CLK cycle.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported range 5..9).

Ports:
CLK  input  1  bit clock
RST  input  1  synchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel byte to send
Data_Valid  input  1  P_DATA valid; accepted only while busy=0
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
mux_sel  output  2  00 start, 01 data, 10 parity, 11 idle/stop
serial_data  output  1  current data bit (LSB first)
parity_bit  output  1  parity of latched byte
busy  output  1  frame in progress

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST), sampled on posedge CLK only.
- Reset values: state IDLE, mux_sel=11, serial_data=0, parity_bit=0, busy=0, bit counter=0, shift register=0.
- RST high mid-frame: at the next edge, return to the reset values above. The latched byte is discarded and the frame is not resumed.
- State machine (Moore):
  - IDLE: mux_sel=11, busy=0.
  - START: mux_sel=00, busy=1.
  - DATA: mux_sel=01, busy=1.
  - PARITY: mux_sel=10, busy=1.
  - STOP: mux_sel=11, busy=1.
- Transitions:
  - IDLE -> START when Data_Valid=1 at the edge.
  - START -> DATA unconditionally.
  - DATA stays DATA for DATA_WIDTH cycles, then goes to PARITY if latched PAR_EN=1, otherwise to STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Acceptance: on the IDLE edge where Data_Valid=1, latch P_DATA into the shift register and latch PAR_EN and PAR_TYP. Data_Valid in any other state is ignored and not queued. Input changes after acceptance do not affect the frame in flight.
- Frame spacing: at least one IDLE cycle between frames. Data_Valid held high continuously therefore gives a frame every DATA_WIDTH+3 cycles (+1 with parity).
- Serializer:
  - serial_data = shift_reg[0].
  - The shift register shifts right by one on each DATA-state edge.
  - Bit counter counts 0..DATA_WIDTH-1 in DATA; exit DATA when counter = DATA_WIDTH-1. Counter clears on leaving DATA.
  - serial_data value outside DATA is don't-care for the mux, but it must not toggle in IDLE.
- Parity:
  - parity_bit = XOR-reduce(latched byte) XOR latched PAR_TYP.
  - Registered at acceptance and held constant until the next acceptance.
- Timing: let Data_Valid be sampled at edge k.
  - mux_sel=00 during cycle k+1.
  - Data bit i is present during cycle k+2+i.
  - Parity (if enabled) during cycle k+2+DATA_WIDTH.
  - STOP during the following cycle, then IDLE.
  - The downstream mux adds one register stage, so the line lags mux_sel by one cycle.
- All outputs are registered or decoded only from registered state (no input-to-output combinational path).

Test Plan:
- Reset: assert RST for 2 cycles with Data_Valid=1 -> mux_sel=11, busy=0, parity_bit=0; no frame starts while RST is high.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, pulse Data_Valid -> mux_sel sequence 00, 01×8, 10, 11. serial_data during DATA = 1,0,1,0,0,1,0,1. parity_bit=0. busy high for exactly 11 cycles.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> parity_bit=1. P_DATA=0x01, PAR_TYP=0 -> parity_bit=1.
- P_DATA=0x3C, PAR_EN=0 -> mux_sel 00, 01×8, 11; no 10 ever appears; busy high 10 cycles. serial_data = 0,0,1,1,1,1,0,0.
- Change P_DATA/PAR_EN and pulse Data_Valid mid-frame -> current frame unchanged. Hold Data_Valid high continuously -> consecutive frames separated by exactly one IDLE cycle.
- Assert RST during DATA bit 3 -> next cycle mux_sel=11, busy=0. A new Data_Valid after reset sends a complete fresh frame.
